md_unit: RTL

Parametrised multiply/divide unit for the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers, runs multi-cycle multiply, divide and multiply-accumulate operations, and services mfhi/mflo/mthi/mtlo. It raises `busy` so the hazard controller can stall later HI/LO instructions. This generation adds configurable width and latencies, accumulate modes, and divide-by-zero protection.

---
 rtl/md_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide/accumulate unit with mthi/mtlo/mfhi/mflo access.
// Latency: MULT_LAT cycles (mult/acc) or DIV_LAT cycles (div); rd_data is combinational.
// Backpressure: busy holds high while an op is in flight; start and write_hl are ignored then.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       write_hl,
    input  logic [1:0]       read_hl,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } md_req_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    md_req_t         req;

    logic            op_vld;
    logic            op_is_div;
    logic            req_signed;
    logic [2*WIDTH-1:0] hilo, prod_s, prod_u, prod, acc_add, acc_sub;
    logic            a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, div_b, uq, ur, quo, rem;

    assign op_vld    = (md_op >= OP_MULT) && (md_op <= OP_MSUBU);
    assign op_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

    // Odd op codes are the signed variants.
    assign req_signed = req.op[0];

    always_comb begin
        hilo    = {hi, lo};
        prod_s  = {{WIDTH{req.a[WIDTH-1]}}, req.a} * {{WIDTH{req.b[WIDTH-1]}}, req.b};
        prod_u  = {{WIDTH{1'b0}}, req.a} * {{WIDTH{1'b0}}, req.b};
        prod    = req_signed ? prod_s : prod_u;
        acc_add = hilo + prod;
        acc_sub = hilo - prod;
    end

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        a_neg = req_signed && req.a[WIDTH-1];
        b_neg = req_signed && req.b[WIDTH-1];
        a_mag = a_neg ? (WIDTH'(0) - req.a) : req.a;
        b_mag = b_neg ? (WIDTH'(0) - req.b) : req.b;
        div_b = (b_mag == '0) ? WIDTH'(1) : b_mag;
        uq    = a_mag / div_b;
        ur    = a_mag % div_b;
        quo   = (a_neg ^ b_neg) ? (WIDTH'(0) - uq) : uq;
        rem   = a_neg ? (WIDTH'(0) - ur) : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            req   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_vld) begin
                            req   <= '{op: md_op, a: a, b: b};
                            cnt   <= op_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        case (write_hl)
                            2'd1:    hi <= a;
                            2'd2:    lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        case (req.op)
                            OP_MULT, OP_MULTU: {hi, lo} <= prod;
                            OP_DIV, OP_DIVU: begin
                                if (req.b != '0) begin
                                    lo <= quo;
                                    hi <= rem;
                                end
                            end
                            OP_MADD, OP_MADDU: {hi, lo} <= acc_add;
                            OP_MSUB, OP_MSUBU: {hi, lo} <= acc_sub;
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (read_hl)
            2'd1:    rd_data = hi;
            2'd2:    rd_data = lo;
            default: rd_data = '0;
        endcase
    end

endmodule
